// File: rtl/uart_rx_word_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_word_loader_if
//  Description : Receiver handshake and instruction-memory write bundle for
//                the UART boot-load word loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_word_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_flag;
    logic              rx_flag_clr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;

    // Loader side
    modport slave (
        input  rx_data, rx_flag,
        output rx_flag_clr, mem_we, mem_addr, mem_wdata, busy, done, error
    );

    // Receiver / memory / system side
    modport master (
        output rx_data, rx_flag,
        input  rx_flag_clr, mem_we, mem_addr, mem_wdata, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_word_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_word_loader
//  Description : Parses a framed UART boot stream (header, 16-bit word count,
//                little-endian words) and writes words to instruction memory.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_word_loader #(
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         ADDR_W    = 10,
    parameter int         BASE_ADDR = 0,
    parameter int         TIMEOUT   = 1_000_000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    uart_rx_word_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int               c_TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [32:0]      c_MAX_WORDS = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_flag_clr;
    logic [15:0]         r_count;
    logic [15:0]         r_index;
    logic [1:0]          r_lane;
    logic [31:0]         r_wdata;
    logic [c_TO_W-1:0]   r_idle_cnt;
    logic                r_done;
    logic                r_error;

    logic                w_can_take;
    logic                w_accept;
    logic                w_counting;
    logic                w_timeout;
    logic                w_header;
    logic [15:0]         w_count_full;
    logic [15:0]         w_index_inc;

    // A byte is only sampled when the previous clear pulse has finished.
    assign w_can_take   = (r_state == S_IDLE) || (r_state == S_CNT_LO) ||
                          (r_state == S_CNT_HI) || (r_state == S_DATA);
    assign w_accept     = bus.rx_flag && !r_rx_flag_clr && w_can_take;
    assign w_counting   = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                          (r_state == S_DATA);
    assign w_timeout    = (r_idle_cnt == c_TO_LAST);
    assign w_header     = (r_state == S_IDLE) && w_accept && (bus.rx_data == HEADER);
    assign w_count_full = {bus.rx_data, r_count[7:0]};
    assign w_index_inc  = r_index + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_header) w_state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (w_accept)       w_state_nxt = S_CNT_HI;
                else if (w_timeout) w_state_nxt = S_ERR;
            end
            S_CNT_HI: begin
                if (w_accept) begin
                    if (w_count_full == 16'd0)                      w_state_nxt = S_DONE;
                    else if ({17'd0, w_count_full} > c_MAX_WORDS)   w_state_nxt = S_ERR;
                    else                                            w_state_nxt = S_DATA;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                // A byte arriving on the terminal count wins over the timeout.
                if (w_accept) begin
                    if (r_lane == 2'd3) w_state_nxt = S_WRITE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                w_state_nxt = (w_index_inc == r_count) ? S_DONE : S_DATA;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_flag_clr <= 1'b0;
            r_count       <= 16'd0;
            r_index       <= 16'd0;
            r_lane        <= 2'd0;
            r_wdata       <= 32'd0;
            r_idle_cnt    <= '0;
        end else begin
            r_rx_flag_clr <= w_accept;

            if (w_accept || !w_counting) r_idle_cnt <= '0;
            else                         r_idle_cnt <= r_idle_cnt + 1'b1;

            if (w_accept) begin
                case (r_state)
                    S_CNT_LO: r_count[7:0]  <= bus.rx_data;
                    S_CNT_HI: begin
                        r_count[15:8] <= bus.rx_data;
                        r_index       <= 16'd0;
                        r_lane        <= 2'd0;
                    end
                    S_DATA: begin
                        r_wdata[{r_lane, 3'b000} +: 8] <= bus.rx_data;
                        r_lane                         <= r_lane + 2'd1;
                    end
                    default: ;
                endcase
            end

            if (r_state == S_WRITE) r_index <= w_index_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else if (w_header) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else if (w_state_nxt == S_DONE) begin
            r_done  <= 1'b1;
            r_error <= 1'b0;
        end else if (w_state_nxt == S_ERR) begin
            r_done  <= 1'b0;
            r_error <= 1'b1;
        end
    end

    assign bus.rx_flag_clr = r_rx_flag_clr;
    assign bus.mem_we      = (r_state == S_WRITE);
    assign bus.mem_addr    = (r_state == S_WRITE) ?
                             (ADDR_W'(BASE_ADDR) + r_index[ADDR_W-1:0]) : '0;
    assign bus.mem_wdata   = r_wdata;
    assign bus.busy        = w_counting || (r_state == S_WRITE);
    assign bus.done        = r_done;
    assign bus.error       = r_error;

endmodule
`default_nettype wire

// File: doc/uart_rx_word_loader.md
# uart_rx_word_loader

Sequencing controller for the UART receiver datapath. It consumes received bytes through the receiver's `rx_flag` / `rx_flag_clr` handshake and parses a framed boot-load stream. It assembles little-endian 32-bit words and writes them to instruction memory at auto-incrementing addresses. While a load is in progress it holds the processor core in reset.

## Interface
- `HEADER`, default 8'hA5: frame start byte.
- `ADDR_W`, default 10: width of the memory word address.
- `BASE_ADDR`, default 0: word address of the first write.
- `TIMEOUT`, default 1_000_000: maximum idle clock cycles between bytes inside a frame.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid while `rx_flag`=1.
- `rx_flag`  in  1  byte available; level, held by the receiver until cleared.
- `rx_flag_clr`  out  1  one-cycle pulse that clears `rx_flag`.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  write data.
- `busy`  out  1  frame in progress; core held in reset.
- `done`  out  1  sticky: last frame completed.
- `error`  out  1  sticky: last frame aborted.

## Operation
Frame format: `HEADER`, then `CNT_LO` and `CNT_HI` (16-bit word count N, little-endian), then 4·N data bytes, each word little-endian. The first data byte goes to `mem_wdata[7:0]`.

Byte acceptance:
- A byte is accepted at a rising edge where `rx_flag`=1 and `rx_flag_clr`=0.
- That edge captures `rx_data` and drives `rx_flag_clr`=1 for exactly the next cycle.
- `rx_flag` is never sampled while `rx_flag_clr`=1, so no byte is consumed twice.

FSM states:
- **IDLE:** accepted byte == `HEADER` → CNT_LO, and `done`/`error` clear. Any other byte is accepted and discarded; the state stays IDLE.
- **CNT_LO:** accept byte → count[7:0], then go to CNT_HI.
- **CNT_HI:** accept byte → count[15:8].
  - If N == 0 → DONE.
  - If N > 2^ADDR_W − BASE_ADDR → ERR.
  - Otherwise → DATA, with word index = 0 and byte lane = 0.
- **DATA:** each accepted byte is written into lane `lane` of `mem_wdata`, then `lane`++ (2-bit).
  - The byte that fills lane 3 moves the FSM to WRITE.
- **WRITE** (one cycle):
  - `mem_we`=1 and `mem_addr` = BASE_ADDR + index. `mem_wdata` is stable.
  - Next: `index`++. If new index == N → DONE, otherwise → DATA.
  - No byte is accepted in WRITE; a pending `rx_flag` waits.
- **DONE** (one cycle): set `done`, then → IDLE.
- **ERR** (one cycle): set `error`, then → IDLE.

Timeout:
- An idle counter runs in CNT_LO, CNT_HI and DATA.
- It clears on every accepted byte and on entry to CNT_LO.
- When it reaches `TIMEOUT`−1 with no byte accepted → ERR.

Flags and outputs:
- `busy` = 1 in states CNT_LO, CNT_HI, DATA and WRITE.
- `done` and `error` are mutually exclusive. They hold until the next `HEADER` is accepted or `rst`.
- `mem_we` is asserted only in WRITE, so exactly N strobes occur per good frame.
- A frame aborted by ERR leaves the words already written in memory.

Arithmetic: `index` is 16 bits. `mem_addr` = BASE_ADDR + index[ADDR_W-1:0]. The range check in CNT_HI guarantees the address never wraps.

## Timing
- Reset values:
  - All outputs = 0, including `mem_addr` and `mem_wdata`.
  - State = IDLE; counters, lane and index = 0.
- `rst` mid-frame: state → IDLE next edge, all outputs 0; `done`/`error` cleared.
- Accept latency: accept edge E, `rx_flag_clr`=1 during cycle E..E+1. The receiver drops `rx_flag` at edge E+1.
- Write latency: the edge accepting lane-3 byte → `mem_we`=1 in the following cycle, with final `mem_wdata` already valid.
- Minimum byte spacing: one accept every 2 cycles. UART byte time far exceeds this.
- `done`/`error` rise one cycle after the last WRITE, the CNT_HI accept, or the timeout. `busy` falls in the same cycle.
- A simultaneous timeout terminal count and byte arrival resolves to accepting the byte; there is no error.

## Test plan
- **Good frame:** A5,02,00,78,56,34,12,EF,BE,AD,DE.
  - Expect 2 `mem_we` pulses: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF.
  - Then `done`=1, `busy`=0 and `error`=0.
- **Garbage then zero-count frame:** 00,FF,A5,00,00 → the first two bytes are cleared and ignored, no `mem_we`, `done`=1. Every byte gets exactly one `rx_flag_clr` pulse.
- **Oversize count** (ADDR_W=10): A5,01,04 (N=1025) → `error`=1, no `mem_we`, state back to IDLE.
- **Timeout** (TIMEOUT=100): A5,01,00,11,22 then silence → `error`=1 at 100 cycles after the last accept; `busy`=0 and no write.
- **Reset mid-DATA:** after 2 data bytes assert `rst` → all outputs 0 next cycle. A following good 1-word frame writes addr 0 with correct data.
- **Handshake hold:** keep `rx_flag` high through a WRITE cycle → the byte is accepted only after WRITE, with no duplicate capture.
